// File: rtl/awg_pkg.sv
// Shared definitions for the waveform-generator signal chain: word widths,
// DAC streamer state encoding and SPI frame packing.
package awg_pkg;

    localparam int DATA_W  = 10;
    localparam int FRAME_W = 16;
    localparam int CTRL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } dac_state_e;

    localparam logic [CTRL_W-1:0] DEF_CTRL_BITS = 4'b0000;

    // DAC frame layout: command nibble, sample, two don't-care LSBs.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [CTRL_W-1:0] ctrl,
                                                       input logic [DATA_W-1:0] data);
        return {ctrl, data, 2'b00};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV clocks while enabled.
// The counter restarts from 0 whenever enable is low or clear is asserted.
module tick_gen #(
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick_q;

    // tick_q is registered off the terminal count, so the first tick lands
    // exactly SAMPLE_DIV cycles after enable rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (!enable || clear) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q & enable;

endmodule

// File: rtl/dac_spi_streamer.sv
// Samples waveform data at a fixed rate and serialises each sample as a
// 16-bit SPI mode-0 frame to a serial DAC, counting ticks lost while busy.
module dac_spi_streamer
    import awg_pkg::*;
#(
    parameter int                SCLK_HALF  = 2,
    parameter int                SAMPLE_DIV = 100,
    parameter int                CS_HOLD    = 4,
    parameter logic [CTRL_W-1:0] CTRL_BITS  = DEF_CTRL_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_data,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_cs_n,
    output logic              busy,
    output logic              sample_taken,
    output logic [7:0]        overrun_cnt,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_SHIFT = 2'(SHIFT);
    localparam logic [1:0] S_HOLD  = 2'(HOLD);

    localparam int HW  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int HLW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [HW-1:0]  HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [HLW-1:0] HOLD_LAST = HLW'(CS_HOLD - 1);

    logic [1:0]         state;
    logic [FRAME_W-2:0] shreg;
    logic [HW-1:0]      half_cnt;
    logic [3:0]         bit_cnt;
    logic [HLW-1:0]     hold_cnt;
    logic               tick;
    logic [FRAME_W-1:0] frame;

    tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .clear (1'b0),
        .tick  (tick)
    );

    assign frame = build_frame(CTRL_BITS, sample_data);

    // Capture strobe: sample_data is consumed only in a cycle where tick is
    // high and the serialiser is idle; sample_taken marks exactly that cycle.
    assign sample_taken = tick && (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            hold_cnt    <= '0;
            dac_sclk    <= 1'b0;
            dac_mosi    <= 1'b0;
            dac_cs_n    <= 1'b1;
            overrun_cnt <= '0;
        end else begin
            if (tick && (state != S_IDLE) && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        shreg    <= frame[FRAME_W-2:0];
                        dac_mosi <= frame[FRAME_W-1];
                        dac_cs_n <= 1'b0;
                        dac_sclk <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else if (bit_cnt == 4'd15) begin
                            dac_sclk <= 1'b0;
                            dac_cs_n <= 1'b1;
                            dac_mosi <= 1'b0;
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end else begin
                            // Data only moves on the falling edge, so the DAC
                            // sees it stable across each rising edge.
                            dac_sclk <= 1'b0;
                            dac_mosi <= shreg[FRAME_W-2];
                            shreg    <= {shreg[FRAME_W-3:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    dac_cs_n <= 1'b1;
                    dac_sclk <= 1'b0;
                    dac_mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Bench for dac_spi_streamer: three instances (defaults, slow SCLK, fast
// sample rate) with a frame monitor that decodes SPI traffic against exp queues.
module tb_dac_spi_streamer;

    logic       clk = 1'b0;
    int         cyc = 0;
    logic [2:0] rst_w = 3'b111;
    logic [2:0] en_w  = 3'b000;
    logic [9:0] data_a = '0, data_b = '0, data_c = '0;
    logic [2:0] sclk_w, mosi_w, cs_w, busy_w, taken_w;
    logic [7:0] ovr_a, ovr_b, ovr_c;
    logic [1:0] st_a, st_b, st_c;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_q_b[$];
    logic [15:0] exp_q_c[$];

    // monitor state per instance
    bit          in_frame[3];
    bit          seen_end[3];
    logic        sclk_p[3];
    logic        cs_p[3];
    logic [15:0] word[3];
    int          bits[3], frames[3], taken_n[3], taken_c[3];
    int          start_c[3], last_tog[3], last_end[3], phase_err[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_streamer u_a (
        .clk(clk), .rst(rst_w[0]), .enable(en_w[0]), .sample_data(data_a),
        .dac_sclk(sclk_w[0]), .dac_mosi(mosi_w[0]), .dac_cs_n(cs_w[0]),
        .busy(busy_w[0]), .sample_taken(taken_w[0]), .overrun_cnt(ovr_a),
        .state_dbg(st_a)
    );

    dac_spi_streamer #(.SCLK_HALF(3), .SAMPLE_DIV(40), .CS_HOLD(5)) u_b (
        .clk(clk), .rst(rst_w[1]), .enable(en_w[1]), .sample_data(data_b),
        .dac_sclk(sclk_w[1]), .dac_mosi(mosi_w[1]), .dac_cs_n(cs_w[1]),
        .busy(busy_w[1]), .sample_taken(taken_w[1]), .overrun_cnt(ovr_b),
        .state_dbg(st_b)
    );

    dac_spi_streamer #(.SAMPLE_DIV(40)) u_c (
        .clk(clk), .rst(rst_w[2]), .enable(en_w[2]), .sample_data(data_c),
        .dac_sclk(sclk_w[2]), .dac_mosi(mosi_w[2]), .dac_cs_n(cs_w[2]),
        .busy(busy_w[2]), .sample_taken(taken_w[2]), .overrun_cnt(ovr_c),
        .state_dbg(st_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int half_of(input int i);
        return (i == 1) ? 3 : 2;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 1) ? 5 : 4;
    endfunction

    task automatic end_frame(input int i);
        logic [15:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        case (i)
            0: if (exp_q.size() > 0) begin e = exp_q.pop_front(); have = 1'b1; end
            1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1'b1; end
            default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); have = 1'b1; end
        endcase
        chk($sformatf("frame_expected_%0d", i), 32'(have), 32'd1);
        chk($sformatf("frame_word_%0d", i), 32'(word[i]), 32'(e));
        chk($sformatf("frame_bits_%0d", i), bits[i], 16);
        chk($sformatf("cs_low_len_%0d", i), cyc - start_c[i], 32 * half_of(i));
        chk($sformatf("sclk_phase_%0d", i), phase_err[i], 0);
    endtask

    task automatic mon_step(input int i);
        if (rst_w[i]) begin
            in_frame[i] = 1'b0;
        end else begin
            if (in_frame[i] && (sclk_w[i] != sclk_p[i])) begin
                if (cyc - last_tog[i] != half_of(i)) phase_err[i]++;
                last_tog[i] = cyc;
                if (sclk_w[i]) begin
                    word[i] = {word[i][14:0], mosi_w[i]};
                    bits[i]++;
                end
            end
            if (in_frame[i] && cs_w[i] && !cs_p[i]) begin
                end_frame(i);
                frames[i]++;
                in_frame[i] = 1'b0;
                seen_end[i] = 1'b1;
                last_end[i] = cyc;
            end
            if (!cs_w[i] && cs_p[i]) begin
                if (seen_end[i])
                    chk($sformatf("cs_high_gap_%0d", i), 32'(cyc - last_end[i] >= hold_of(i)), 32'd1);
                in_frame[i]  = 1'b1;
                start_c[i]   = cyc;
                last_tog[i]  = cyc;
                bits[i]      = 0;
                word[i]      = '0;
                phase_err[i] = 0;
            end
            if (taken_w[i]) begin
                taken_n[i]++;
                taken_c[i] = cyc;
            end
        end
        sclk_p[i] = sclk_w[i];
        cs_p[i]   = cs_w[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon_step(i);
    end

    task automatic wait_bits(input int i, input int n, input int max, input string name);
        int k = 0;
        while (!(in_frame[i] && bits[i] >= n) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(in_frame[i] && bits[i] >= n), 32'd1);
    endtask

    task automatic wait_frames(input int i, input int n, input int max, input string name);
        int k = 0;
        while (frames[i] < n && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, frames[i], n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int en_c, r_c, f0, t0;

        for (int i = 0; i < 3; i++) begin
            sclk_p[i] = 1'b0;
            cs_p[i]   = 1'b1;
        end

        // reset state of all three instances
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_cs_n_%0d", i), 32'(cs_w[i]), 32'd1);
            chk($sformatf("rst_sclk_%0d", i), 32'(sclk_w[i]), 32'd0);
            chk($sformatf("rst_mosi_%0d", i), 32'(mosi_w[i]), 32'd0);
            chk($sformatf("rst_busy_%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_taken_%0d", i), 32'(taken_w[i]), 32'd0);
        end
        chk("rst_ovr_a", 32'(ovr_a), 32'd0);
        chk("rst_ovr_b", 32'(ovr_b), 32'd0);
        chk("rst_ovr_c", 32'(ovr_c), 32'd0);
        rst_w = 3'b000;
        repeat (2) @(negedge clk);

        // single frame at defaults
        data_a = 10'h2A5;
        exp_q.push_back(16'h0A94);
        f0 = frames[0];
        t0 = taken_n[0];
        en_w[0] = 1'b1;
        en_c = cyc;
        wait_bits(0, 0, 150, "a1_start_seen");
        chk("a1_taken_latency", taken_c[0] - en_c, 100);
        chk("a1_cs_latency", start_c[0] - en_c, 101);
        en_w[0] = 1'b0;
        wait_frames(0, f0 + 1, 200, "a1_frame_done");
        repeat (150) @(negedge clk);
        chk("a1_taken_once", taken_n[0] - t0, 1);
        chk("a1_no_extra_frame", frames[0], f0 + 1);

        // data hold: scramble sample_data every cycle after capture
        data_a = 10'h3C1;
        exp_q.push_back(16'h0F04);
        f0 = frames[0];
        en_w[0] = 1'b1;
        wait_bits(0, 0, 150, "a2_start_seen");
        en_w[0] = 1'b0;
        for (int k = 0; k < 200 && frames[0] < f0 + 1; k++) begin
            data_a = 10'($urandom_range(0, 1023));
            @(negedge clk);
        end
        chk("a2_frame_done", frames[0], f0 + 1);

        // enable dropped at bit 4: frame completes, then silence
        data_a = 10'h1FF;
        exp_q.push_back(16'h07FC);
        f0 = frames[0];
        en_w[0] = 1'b1;
        wait_bits(0, 4, 200, "a3_bit4_seen");
        en_w[0] = 1'b0;
        t0 = taken_n[0];
        wait_frames(0, f0 + 1, 200, "a3_frame_done");
        repeat (250) @(negedge clk);
        chk("a3_no_more_frames", frames[0], f0 + 1);
        chk("a3_no_more_taken", taken_n[0], t0);

        // re-enable: tick counter restarts from zero
        data_a = 10'h2A5;
        exp_q.push_back(16'h0A94);
        en_w[0] = 1'b1;
        en_c = cyc;
        wait_bits(0, 0, 150, "a4_start_seen");
        chk("a4_restart_latency", start_c[0] - en_c, 101);

        // asynchronous reset at bit 7 aborts the frame immediately
        wait_bits(0, 7, 200, "a5_bit7_seen");
        @(posedge clk);
        #2;
        rst_w[0] = 1'b1;
        #1;
        chk("a5_rst_cs_n", 32'(cs_w[0]), 32'd1);
        chk("a5_rst_sclk", 32'(sclk_w[0]), 32'd0);
        chk("a5_rst_mosi", 32'(mosi_w[0]), 32'd0);
        chk("a5_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("a5_rst_ovr", 32'(ovr_a), 32'd0);
        chk("a5_rst_state", 32'(st_a), 32'd0);
        exp_q.delete();
        data_a = 10'h0AA;
        exp_q.push_back(16'h02A8);
        f0 = frames[0];
        @(negedge clk);
        @(negedge clk);
        rst_w[0] = 1'b0;
        r_c = cyc;
        wait_bits(0, 0, 150, "a5_post_rst_start");
        chk("a5_post_rst_latency", start_c[0] - r_c, 101);
        en_w[0] = 1'b0;
        wait_frames(0, f0 + 1, 200, "a5_clean_frame");

        // slow SCLK / long CS hold: two frames, overruns between them
        data_b = 10'h155;
        exp_q_b.push_back(16'h0554);
        exp_q_b.push_back(16'h0554);
        f0 = frames[1];
        en_w[1] = 1'b1;
        wait_frames(1, f0 + 2, 400, "b_two_frames");
        en_w[1] = 1'b0;
        repeat (60) @(negedge clk);
        chk("b_overruns", 32'(ovr_b), 32'd4);

        // overrun: SAMPLE_DIV=40 against a 68-cycle busy window
        data_c = 10'h200;
        for (int k = 0; k < 5; k++) exp_q_c.push_back(16'h0800);
        f0 = frames[2];
        t0 = taken_n[2];
        en_w[2] = 1'b1;
        en_c = cyc;
        while (cyc < en_c + 401) @(negedge clk);
        en_w[2] = 1'b0;
        repeat (120) @(negedge clk);
        chk("c_ovr_10_ticks", 32'(ovr_c), 32'd5);
        chk("c_frames_10_ticks", frames[2] - f0, 5);
        chk("c_taken_10_ticks", taken_n[2] - t0, 5);

        data_c = 10'h3FF;
        for (int k = 0; k < 150; k++) exp_q_c.push_back(16'h0FFC);
        f0 = frames[2];
        en_w[2] = 1'b1;
        en_c = cyc;
        while (cyc < en_c + 12001) @(negedge clk);
        en_w[2] = 1'b0;
        repeat (120) @(negedge clk);
        chk("c_ovr_310_ticks", 32'(ovr_c), 32'd155);
        chk("c_frames_300_ticks", frames[2] - f0, 150);

        data_c = 10'h001;
        for (int k = 0; k < 150; k++) exp_q_c.push_back(16'h0004);
        f0 = frames[2];
        en_w[2] = 1'b1;
        en_c = cyc;
        while (cyc < en_c + 12001) @(negedge clk);
        en_w[2] = 1'b0;
        repeat (120) @(negedge clk);
        chk("c_ovr_saturated", 32'(ovr_c), 32'd255);
        chk("c_frames_final", frames[2] - f0, 150);

        chk("a_queue_empty", exp_q.size(), 0);
        chk("b_queue_empty", exp_q_b.size(), 0);
        chk("c_queue_empty", exp_q_c.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
